// File: rtl/spi_dev_pw_mux.sv
// spi_dev_pw_mux
//
// Shares one SPI device protocol-wrapper interface (pw_*) among four
// function ports.
//   - Write path: the command byte of each transaction selects one port
//     (cmd[7:6]); that byte and the following bytes are strobed to that
//     port only. Commands 0xF0-0xFF belong to the core and go nowhere.
//     All u_w* / u_end outputs are registered (1-cycle latency).
//   - Response path: a round-robin arbiter (IDLE/ARB/ACTIVE/RELEASE) picks
//     one requesting port and connects its grant/data/strobe to the core
//     combinationally while it holds the bus.
//   - IRQ: per-port IRQ levels are registered into the status nibble.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pw_wdata/wcmd/wstb/end   write byte, command flag, strobe, CS end (core)
//   pw_req/gnt               response buffer request/grant (to/from core)
//   pw_rdata/rstb            response byte and strobe (to core)
//   pw_irq                   IRQ status nibble (to core)
//   u_wdata/wcmd             write byte and command flag, common to ports
//   u_wstb/u_end             per-port write strobe and transaction end
//   u_req/u_gnt              per-port response request/grant
//   u_rdata/u_rstb           per-port response byte (port i at [8i+7:8i])
//   u_irq                    per-port IRQ level

module spi_dev_pw_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  output logic        pw_req,
  input  logic        pw_gnt,
  output logic [7:0]  pw_rdata,
  output logic        pw_rstb,
  output logic [3:0]  pw_irq,
  output logic [7:0]  u_wdata,
  output logic        u_wcmd,
  output logic [3:0]  u_wstb,
  output logic [3:0]  u_end,
  input  logic [3:0]  u_req,
  output logic [3:0]  u_gnt,
  input  logic [31:0] u_rdata,
  input  logic [3:0]  u_rstb,
  input  logic [3:0]  u_irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ACTIVE,
    ST_RELEASE
  } state_e;

  // Write routing state
  logic [1:0] wsel_q, wsel_d;
  logic       wsel_vld_q, wsel_vld_d;
  logic [7:0] u_wdata_q, u_wdata_d;
  logic       u_wcmd_q, u_wcmd_d;
  logic [3:0] u_wstb_q, u_wstb_d;
  logic [3:0] u_end_q, u_end_d;

  // Response arbitration state
  state_e     state_q, state_d;
  logic [1:0] rsel_q, rsel_d;
  logic [1:0] last_q, last_d;
  logic       pw_req_q, pw_req_d;
  logic [3:0] pw_irq_q;

  // Round-robin search results
  logic       rr_found;
  logic [1:0] rr_pick;
  logic [1:0] rr_idx;

  // ---------------------------------------------------------------------
  // Write routing
  // ---------------------------------------------------------------------
  // NOTE: blocking assignments inside always_comb are evaluated in order,
  // so wsel_d/wsel_vld_d already hold the freshly decoded command when the
  // strobe and end logic below read them; this is how a command byte is
  // routed by its own decode and how a same-cycle pw_end sees it.
  always_comb begin
    wsel_d     = wsel_q;
    wsel_vld_d = wsel_vld_q;
    u_wdata_d  = u_wdata_q;
    u_wcmd_d   = 1'b0;
    u_wstb_d   = 4'b0000;
    u_end_d    = 4'b0000;

    if (pw_wstb && pw_wcmd) begin
      if (pw_wdata[7:4] == 4'hF) begin
        wsel_vld_d = 1'b0;               // core-owned command
      end else begin
        wsel_d     = pw_wdata[7:6];
        wsel_vld_d = 1'b1;
      end
    end

    if (pw_wstb) begin
      u_wdata_d = pw_wdata;
      if (wsel_vld_d) begin
        u_wstb_d[wsel_d] = 1'b1;
        u_wcmd_d         = pw_wcmd;
      end
    end

    // End after the same-cycle byte, then close the transaction.
    if (pw_end) begin
      if (wsel_vld_d) u_end_d[wsel_d] = 1'b1;
      wsel_vld_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Response arbitration: next state
  // ---------------------------------------------------------------------
  always_comb begin
    // First requester after last_q, wrapping; i == 4 lands on last_q itself.
    rr_found = 1'b0;
    rr_pick  = last_q;
    rr_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_q + 2'(i);
      if (!rr_found && u_req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end

    state_d  = state_q;
    rsel_d   = rsel_q;
    last_d   = last_q;
    pw_req_d = pw_req_q;

    case (state_q)
      ST_IDLE: begin
        if (|u_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (rr_found) begin
          rsel_d   = rr_pick;
          last_d   = rr_pick;
          pw_req_d = 1'b1;
          state_d  = ST_ACTIVE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Only the selected port's request matters; others are ignored.
        if (!u_req[rsel_q]) begin
          pw_req_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!pw_gnt) state_d = ST_IDLE;
      end
      default: begin
        pw_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Response arbitration: combinational grant and data path
  // ---------------------------------------------------------------------
  always_comb begin
    u_gnt    = 4'b0000;
    pw_rdata = 8'h00;
    pw_rstb  = 1'b0;
    if (state_q == ST_ACTIVE && pw_gnt) begin
      u_gnt[rsel_q] = 1'b1;
      pw_rdata      = u_rdata[{rsel_q, 3'b000} +: 8];
      pw_rstb       = u_rstb[rsel_q];
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: every flop here is a control/data register with a defined reset
  // value; there is no storage array, so the whole block resets together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_q     <= 2'd0;
      wsel_vld_q <= 1'b0;
      u_wdata_q  <= 8'h00;
      u_wcmd_q   <= 1'b0;
      u_wstb_q   <= 4'b0000;
      u_end_q    <= 4'b0000;
      state_q    <= ST_IDLE;
      rsel_q     <= 2'd0;
      last_q     <= 2'd3;                // port 0 wins the first arbitration
      pw_req_q   <= 1'b0;
      pw_irq_q   <= 4'b0000;
    end else begin
      wsel_q     <= wsel_d;
      wsel_vld_q <= wsel_vld_d;
      u_wdata_q  <= u_wdata_d;
      u_wcmd_q   <= u_wcmd_d;
      u_wstb_q   <= u_wstb_d;
      u_end_q    <= u_end_d;
      state_q    <= state_d;
      rsel_q     <= rsel_d;
      last_q     <= last_d;
      pw_req_q   <= pw_req_d;
      pw_irq_q   <= u_irq;
    end
  end

  assign u_wdata = u_wdata_q;
  assign u_wcmd  = u_wcmd_q;
  assign u_wstb  = u_wstb_q;
  assign u_end   = u_end_q;
  assign pw_req  = pw_req_q;
  assign pw_irq  = pw_irq_q;

endmodule

// File: tb/tb_spi_dev_pw_mux.sv
// Directed testbench for spi_dev_pw_mux. The bench plays both the SPI
// protocol core and the four function ports. Inputs change 1 time unit
// after the rising edge; outputs are checked after a further settle delay.

module tb_spi_dev_pw_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd;
  logic        pw_wstb;
  logic        pw_end;
  logic        pw_req;
  logic        pw_gnt;
  logic [7:0]  pw_rdata;
  logic        pw_rstb;
  logic [3:0]  pw_irq;
  logic [7:0]  u_wdata;
  logic        u_wcmd;
  logic [3:0]  u_wstb;
  logic [3:0]  u_end;
  logic [3:0]  u_req;
  logic [3:0]  u_gnt;
  logic [31:0] u_rdata;
  logic [3:0]  u_rstb;
  logic [3:0]  u_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_dev_pw_mux dut (
    .clk      (clk),
    .rst      (rst),
    .pw_wdata (pw_wdata),
    .pw_wcmd  (pw_wcmd),
    .pw_wstb  (pw_wstb),
    .pw_end   (pw_end),
    .pw_req   (pw_req),
    .pw_gnt   (pw_gnt),
    .pw_rdata (pw_rdata),
    .pw_rstb  (pw_rstb),
    .pw_irq   (pw_irq),
    .u_wdata  (u_wdata),
    .u_wcmd   (u_wcmd),
    .u_wstb   (u_wstb),
    .u_end    (u_end),
    .u_req    (u_req),
    .u_gnt    (u_gnt),
    .u_rdata  (u_rdata),
    .u_rstb   (u_rstb),
    .u_irq    (u_irq)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write-side byte, then check the registered forwarding result.
  task automatic wbyte(input string tag, input logic [7:0] d, input logic cmd,
                       input logic stb, input logic en,
                       input logic [3:0] exp_stb, input logic exp_cmd,
                       input logic [3:0] exp_end);
    pw_wdata = d;
    pw_wcmd  = cmd;
    pw_wstb  = stb;
    pw_end   = en;
    tick();
    pw_wcmd = 1'b0;
    pw_wstb = 1'b0;
    pw_end  = 1'b0;
    check({tag, ".wstb"}, 32'(u_wstb), 32'(exp_stb));
    check({tag, ".end"},  32'(u_end),  32'(exp_end));
    if (exp_stb != 4'b0000) begin
      check({tag, ".wcmd"},  32'(u_wcmd),  32'(exp_cmd));
      check({tag, ".wdata"}, 32'(u_wdata), 32'(d));
    end
  endtask

  // Wait (bounded) for pw_req, grant one cycle later, expect exp_port to be
  // granted, send one byte from it, drop its request and release the grant.
  task automatic serve_one(input string tag, input logic [1:0] exp_port);
    logic [7:0] b;
    for (int i = 0; i < 10 && !pw_req; i++) tick();
    check({tag, ".req"}, 32'(pw_req), 32'd1);
    tick();
    pw_gnt = 1'b1;
    #1;
    check({tag, ".gnt"}, 32'(u_gnt), 32'(4'b0001 << exp_port));
    b = 8'h50 + 8'(exp_port);
    u_rdata[8*exp_port +: 8] = b;
    u_rstb[exp_port] = 1'b1;
    #1;
    check({tag, ".rstb"},  32'(pw_rstb),  32'd1);
    check({tag, ".rdata"}, 32'(pw_rdata), 32'(b));
    tick();
    u_rstb = 4'b0000;
    u_req[exp_port] = 1'b0;
    tick();
    check({tag, ".req_fall"}, 32'(pw_req), 32'd0);
    pw_gnt = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pw_wdata = 8'h00; pw_wcmd = 1'b0; pw_wstb = 1'b0; pw_end = 1'b0;
    pw_gnt = 1'b0; u_req = 4'b0000; u_rdata = 32'h0; u_rstb = 4'b0000;
    u_irq = 4'b0000;
    tick();
    tick();

    // Reset state
    check("rst.pw_req",  32'(pw_req),  32'd0);
    check("rst.pw_rstb", 32'(pw_rstb), 32'd0);
    check("rst.pw_irq",  32'(pw_irq),  32'd0);
    check("rst.u_gnt",   32'(u_gnt),   32'd0);
    check("rst.u_wstb",  32'(u_wstb),  32'd0);
    check("rst.u_wdata", 32'(u_wdata), 32'd0);
    rst = 1'b0;
    tick();

    // Write routing: 0x45 0x11 0x22 end -> port 1
    wbyte("wr.cmd45", 8'h45, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000);
    wbyte("wr.d11",   8'h11, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000);
    wbyte("wr.d22",   8'h22, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000);
    wbyte("wr.end",   8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0010);
    wbyte("wr.idle",  8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    // Stray byte outside any transaction is dropped
    wbyte("wr.stray", 8'h99, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // Reserved command 0xFE, 0x33 -> nothing; then 0xC1 -> port 3
    wbyte("rsv.cmdFE", 8'hFE, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    wbyte("rsv.d33",   8'h33, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    wbyte("rsv.end",   8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    wbyte("p3.cmdC1",  8'hC1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000);
    wbyte("p3.end",    8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000);

    // Range edges: 0xEF -> port 3, 0x3F -> port 0, 0xBF with same-cycle end -> port 2
    wbyte("edge.EF",   8'hEF, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000);
    wbyte("edge.3F",   8'h3F, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000);
    wbyte("edge.3Fd",  8'h5A, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001);
    wbyte("edge.BF",   8'hBF, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100);
    wbyte("edge.after",8'h77, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

    // IRQ: 1-cycle latency
    u_irq = 4'b1010;
    #1;
    check("irq.pre", 32'(pw_irq), 32'd0);
    tick();
    check("irq.lat", 32'(pw_irq), 32'(4'b1010));

    // Single response from port 2: 3 bytes
    u_req = 4'b0100;
    tick();
    check("single.req_c1", 32'(pw_req), 32'd0);
    tick();
    check("single.req_c2", 32'(pw_req), 32'd1);
    check("single.nognt",  32'(u_gnt),  32'd0);
    tick();
    pw_gnt = 1'b1;
    #1;
    check("single.gnt", 32'(u_gnt), 32'(4'b0100));
    for (int k = 0; k < 3; k++) begin
      u_rdata[23:16] = 8'hA0 + 8'(k);
      u_rstb[2] = 1'b1;
      #1;
      check("single.rstb",  32'(pw_rstb),  32'd1);
      check("single.rdata", 32'(pw_rdata), 32'(8'hA0 + 8'(k)));
      tick();
    end
    u_rstb = 4'b0000;
    u_req  = 4'b0000;
    #1;
    check("single.req_hold", 32'(pw_req), 32'd1);
    tick();
    check("single.req_fall", 32'(pw_req), 32'd0);
    check("single.rel_gnt",  32'(u_gnt),  32'd0);
    check("single.rel_rstb", 32'(pw_rstb), 32'd0);
    pw_gnt = 1'b0;
    tick();

    // Round-robin from reset (last=3): 0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_req = 4'b1111;
    serve_one("rr0.p0", 2'd0);
    serve_one("rr0.p1", 2'd1);
    serve_one("rr0.p2", 2'd2);
    serve_one("rr0.p3", 2'd3);

    // Set last=1 with a lone port-1 request, then all four: 2,3,0,1
    u_req = 4'b0010;
    serve_one("rr1.set", 2'd1);
    u_req = 4'b1111;
    serve_one("rr1.p2", 2'd2);
    serve_one("rr1.p3", 2'd3);
    serve_one("rr1.p0", 2'd0);
    serve_one("rr1.p1", 2'd1);

    // Abort: port 0 drops request before grant
    u_req = 4'b0001;
    for (int i = 0; i < 10 && !pw_req; i++) tick();
    check("abort.req", 32'(pw_req), 32'd1);
    u_req = 4'b0000;
    tick();
    check("abort.req_fall", 32'(pw_req), 32'd0);
    pw_gnt = 1'b1;                      // late grant from the core
    #1;
    check("abort.no_gnt", 32'(u_gnt), 32'd0);
    tick();
    check("abort.no_gnt2", 32'(u_gnt), 32'd0);
    pw_gnt = 1'b0;
    tick();
    // Back in IDLE: a new request takes exactly 2 cycles
    u_req = 4'b0001;
    tick();
    check("abort.idle_c1", 32'(pw_req), 32'd0);
    tick();
    check("abort.idle_c2", 32'(pw_req), 32'd1);
    u_req = 4'b0000;
    tick();
    tick();

    // Reset mid-grant: port 2 active with grant
    u_req = 4'b0100;
    for (int i = 0; i < 10 && !pw_req; i++) tick();
    pw_gnt = 1'b1;
    u_rdata[23:16] = 8'hC3;
    u_rstb[2] = 1'b1;
    #1;
    check("rmid.gnt", 32'(u_gnt), 32'(4'b0100));
    rst = 1'b1;
    tick();
    check("rmid.pw_req", 32'(pw_req),   32'd0);
    check("rmid.u_gnt",  32'(u_gnt),    32'd0);
    check("rmid.irq",    32'(pw_irq),   32'd0);
    check("rmid.rstb",   32'(pw_rstb),  32'd0);
    check("rmid.rdata",  32'(pw_rdata), 32'd0);
    rst = 1'b0;
    pw_gnt = 1'b0;
    u_rstb = 4'b0000;
    u_req = 4'b1111;
    serve_one("rmid.prio", 2'd0);
    u_req = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_dev_pw_mux.md
# spi_dev_pw_mux

Shares the SPI device protocol-wrapper interface (`pw_*`) among four function ports. Write/request traffic is routed to one port per SPI transaction, selected by the command byte. Response access is arbitrated round-robin among the ports' requests. Per-port IRQ lines are merged into the 4-bit status nibble. The block sits between the SPI protocol core and the user function blocks (register bank, memory bridge, etc.).

## Interface
- No parameters; port count is fixed at 4 (index 0..3).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pw_wdata` in 8: write byte from the protocol core.
- `pw_wcmd` in 1: current byte is the first byte (command) of the transaction.
- `pw_wstb` in 1: write byte strobe.
- `pw_end` in 1: transaction end (CS rising).
- `pw_req` out 1: response buffer request to the core.
- `pw_gnt` in 1: response buffer grant from the core.
- `pw_rdata` out 8: response byte to the core.
- `pw_rstb` out 1: response byte strobe to the core.
- `pw_irq` out 4: IRQ status nibble to the core.
- `u_wdata` out 8: write byte, common to all ports.
- `u_wcmd` out 1: command flag, common to all ports.
- `u_wstb` out 4: per-port write strobe.
- `u_end` out 4: per-port transaction end.
- `u_req` in 4: per-port response request.
- `u_gnt` out 4: per-port response grant.
- `u_rdata` in 4x8 (32, port i at bits [8i+7:8i]): per-port response byte.
- `u_rstb` in 4: per-port response strobe.
- `u_irq` in 4: per-port IRQ level.

## Operation
**Write routing.** Selection register `wsel` (2 bits) plus `wsel_vld`.
- On `pw_wstb & pw_wcmd`:
  - If `pw_wdata[7:4] == 4'hF`: `wsel_vld` <= 0. Commands 0xF0-0xFF are reserved for the core (NOP 0xFF, RESP_ACK 0xFE) and routed nowhere.
  - Otherwise: `wsel` <= `pw_wdata[7:6]`, `wsel_vld` <= 1. 0x00-0x3F go to port 0, 0x40-0x7F to port 1, 0x80-0xBF to port 2, 0xC0-0xEF to port 3.
- The command byte is forwarded with `u_wcmd`=1 and `u_wstb[sel]`=1, using the newly decoded selection.
- Following bytes with `wsel_vld`: `u_wstb[wsel]`=1, `u_wcmd`=0. Without `wsel_vld`, bytes are dropped.
- On `pw_end`: `u_end[wsel]` pulses if `wsel_vld`; then `wsel_vld` <= 0. `pw_end` and `pw_wstb` in the same cycle: the byte is forwarded first, with the same-cycle `u_end`.

**Response arbitration.** FSM with states IDLE, ARB, ACTIVE, RELEASE; 2-bit pointer `last`.
- IDLE: if `|u_req`, go to ARB.
- ARB: `rsel` <= first set bit of `u_req`, searching from `last+1` with wrap. `last` <= `rsel`. Go to ACTIVE. If `u_req` is all zero, return to IDLE.
- ACTIVE: `pw_req`=1 (registered).
  - `u_gnt[rsel]` = `pw_gnt` (combinational, only in ACTIVE).
  - `pw_rdata`/`pw_rstb` = `u_rdata`/`u_rstb` of `rsel`, only while `u_gnt[rsel]`; otherwise `pw_rstb`=0 and `pw_rdata`=0.
  - `u_req[rsel]` low, with or without a prior grant: go to RELEASE, `pw_req` <= 0.
- RELEASE: `pw_req`=0. Wait for `pw_gnt`=0, then go to IDLE.
- Requesters raised or dropped for non-selected ports never affect the active one.
- Requester rule: `u_rstb` only while its `u_gnt` is high, and never in the cycle `u_req` falls.

**IRQ.** `pw_irq` <= `u_irq` (registered, bit i = port i).

## Timing
- Reset: `pw_req`=0, `pw_rstb`=0, `pw_rdata`=0, `pw_irq`=0, `u_gnt`=0, `u_wstb`=0, `u_end`=0, `u_wcmd`=0, `u_wdata`=0, FSM in IDLE, `wsel_vld`=0, `last`=3 (port 0 wins first).
- Write path: all `u_w*` and `u_end` are registered, 1-cycle latency from `pw_*`. The byte order is preserved.
- Response request: `u_req` rise to `pw_req` rise takes 2 cycles (IDLE, then ARB).
- `u_req[rsel]` fall to `pw_req` fall takes 1 cycle.
- Grant and data paths are combinational (0 cycles).
- Back-to-back: after RELEASE, the next grant is at least 3 cycles after `pw_gnt` falls.
- Round-robin: with all ports requesting continuously, the order is 0,1,2,3,0. No port waits more than 3 other grants.
- `rst` mid-transaction: everything returns to reset values the next cycle; an in-flight grant is abandoned (the core sees `pw_req`=0).
- IRQ latency is 1 cycle.

## Test plan
- Write routing: transaction 0x45,0x11,0x22 then end -> port 1 sees `u_wcmd`=1 with 0x45, then 0x11 and 0x22, then `u_end[1]`; ports 0, 2 and 3 see no strobes.
- Reserved command: transaction 0xFE,0x33 -> no `u_wstb` and no `u_end` on any port. A following 0xC1 transaction goes to port 3.
- Single response: port 2 requests; bench core grants 1 cycle after `pw_req`; port streams 3 bytes 0xA0,0xA1,0xA2 then drops req -> `pw_rstb` fires 3 times with the same data, and `pw_req` falls 1 cycle after `u_req[2]`.
- Round-robin: all 4 ports request simultaneously and each sends 1 byte -> grant order 0,1,2,3. A repeat starting with `last`=1 gives order 2,3,0,1.
- Abort: port 0 drops req before `pw_gnt` -> `pw_req` falls; `u_gnt[0]` never asserts; FSM returns to IDLE after `pw_gnt`=0.
- Reset mid-grant: `rst` asserted while ACTIVE with grant -> next cycle `pw_req`=0, `u_gnt`=0, `pw_irq`=0; after release, port 0 has priority.
